// File: rtl/ctrl_exp_timer_param.sv
// Exposure-time controller: button-stepped setting in IDLE, prescaled countdown in EXPOSURE.
// Optional auto-repeat of held buttons is enabled by defining CTRL_EXP_AUTOREPEAT_EN.
module ctrl_exp_timer_param #(
    parameter int WIDTH         = 5,
    parameter int T_MIN         = 2,
    parameter int T_MAX         = 30,
    parameter int T_INIT        = 10,
    parameter int STEP          = 1,
    parameter int PRESCALE      = 4,
    parameter int REPEAT_CYCLES = 8
) (
    input  logic             i_Clock,
    input  logic             i_Reset_n,
    input  logic             i_Exp_increase,
    input  logic             i_Exp_decrease,
    input  logic [1:0]       i_Main_FSM,
    output logic [WIDTH-1:0] o_count_time,
    output logic [WIDTH-1:0] o_time_left,
    output logic             o_Exp_busy,
    output logic             o_Exp_done
);

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0]  PS_LAST = PW'(PRESCALE - 1);
    localparam logic [WIDTH:0] STEP_X  = (WIDTH+1)'(STEP);
    localparam logic [WIDTH:0] T_MIN_X = (WIDTH+1)'(T_MIN);
    localparam logic [WIDTH:0] T_MAX_X = (WIDTH+1)'(T_MAX);

    if (T_MIN < 1 || T_MAX >= (1 << WIDTH) || T_INIT < T_MIN || T_INIT > T_MAX ||
        STEP < 1 || PRESCALE < 1 || REPEAT_CYCLES < 1) begin : g_param_check
        $error("ctrl_exp_timer_param: illegal parameter combination");
    end

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_HOLD} state_t;

    state_t          state, state_next;
    logic            inc_prev, dec_prev, exp_prev;
    logic [PW-1:0]   prescaler;
    logic            main_idle, exp_now, entry, prescale_wrap;
    logic            inc_edge, dec_edge, req_inc, req_dec;
    logic            load, tick, finish;
    logic [WIDTH:0]  inc_sum;
    logic [WIDTH-1:0] inc_val, dec_val;

    assign main_idle     = (i_Main_FSM == 2'b00);
    assign exp_now       = (i_Main_FSM == 2'b01);
    assign entry         = exp_now && !exp_prev;
    assign prescale_wrap = (prescaler == PS_LAST);
    assign inc_edge      = i_Exp_increase && !inc_prev;
    assign dec_edge      = i_Exp_decrease && !dec_prev;

    // Widened sum so saturation is decided before any wrap can happen.
    assign inc_sum = {1'b0, o_count_time} + STEP_X;
    assign inc_val = (inc_sum > T_MAX_X) ? WIDTH'(T_MAX) : inc_sum[WIDTH-1:0];
    assign dec_val = ({1'b0, o_count_time} < T_MIN_X + STEP_X) ? WIDTH'(T_MIN)
                                                               : o_count_time - WIDTH'(STEP);

`ifdef CTRL_EXP_AUTOREPEAT_EN
    localparam int RW = (REPEAT_CYCLES > 1) ? $clog2(REPEAT_CYCLES) : 1;
    localparam logic [RW-1:0] RPT_LAST = RW'(REPEAT_CYCLES - 1);

    logic [RW-1:0] rpt_cnt;
    logic          rpt_armed, held_one, rpt_fire;

    assign held_one = i_Exp_increase ^ i_Exp_decrease;
    assign rpt_fire = main_idle && rpt_armed && held_one && (rpt_cnt == RPT_LAST) &&
                      !(inc_edge || dec_edge);
    assign req_inc  = inc_edge || (rpt_fire && i_Exp_increase);
    assign req_dec  = dec_edge || (rpt_fire && i_Exp_decrease);

    // Repeat is armed only by an edge step and disarmed by release, both buttons, or leaving IDLE.
    always_ff @(posedge i_Clock or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            rpt_cnt   <= '0;
            rpt_armed <= 1'b0;
        end else if (!main_idle || !held_one) begin
            rpt_cnt   <= '0;
            rpt_armed <= 1'b0;
        end else if (inc_edge || dec_edge) begin
            rpt_cnt   <= '0;
            rpt_armed <= 1'b1;
        end else if (rpt_armed) begin
            rpt_cnt   <= rpt_fire ? '0 : rpt_cnt + 1'b1;
        end
    end
`else
    assign req_inc = inc_edge;
    assign req_dec = dec_edge;
`endif

    // NOTE: every signal gets a default first so no path through the case infers a latch.
    always_comb begin
        state_next = state;
        load       = 1'b0;
        tick       = 1'b0;
        finish     = 1'b0;
        if (entry) begin
            state_next = S_RUN;
            load       = 1'b1;
        end else begin
            case (state)
                S_RUN: begin
                    if (!exp_now) begin
                        state_next = S_HOLD;
                    end else if (prescale_wrap) begin
                        tick = 1'b1;
                        if (o_time_left == WIDTH'(1)) begin
                            finish     = 1'b1;
                            state_next = S_HOLD;
                        end
                    end
                end
                S_HOLD: begin
                    if (main_idle) state_next = S_IDLE;
                end
                default: ;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge i_Clock or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge i_Clock or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            inc_prev     <= 1'b0;
            dec_prev     <= 1'b0;
            exp_prev     <= 1'b0;
            o_count_time <= WIDTH'(T_INIT);
        end else begin
            inc_prev <= i_Exp_increase;
            dec_prev <= i_Exp_decrease;
            exp_prev <= exp_now;
            if (main_idle) begin
                if (req_inc && !req_dec)      o_count_time <= inc_val;
                else if (req_dec && !req_inc) o_count_time <= dec_val;
            end
        end
    end

    always_ff @(posedge i_Clock or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            prescaler   <= '0;
            o_time_left <= '0;
            o_Exp_busy  <= 1'b0;
            o_Exp_done  <= 1'b0;
        end else begin
            o_Exp_busy <= (state_next == S_RUN);
            o_Exp_done <= finish;
            if (load) begin
                prescaler   <= '0;
                o_time_left <= o_count_time;
            end else if (state == S_RUN && exp_now) begin
                prescaler <= prescale_wrap ? '0 : prescaler + 1'b1;
                if (tick) o_time_left <= o_time_left - 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ctrl_exp_timer_param.sv
// Directed bench for ctrl_exp_timer_param: vector table for button stepping,
// hand sequences for saturation, countdown, abort, async reset and auto-repeat.
module tb_ctrl_exp_timer_param;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       inc, dec;
    logic [1:0] fsm;
    logic [4:0] count_time, time_left;
    logic       busy, done;

    int passed = 0;
    int total  = 0;

    ctrl_exp_timer_param dut (
        .i_Clock        (clk),
        .i_Reset_n      (rst_n),
        .i_Exp_increase (inc),
        .i_Exp_decrease (dec),
        .i_Main_FSM     (fsm),
        .o_count_time   (count_time),
        .o_time_left    (time_left),
        .o_Exp_busy     (busy),
        .o_Exp_done     (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       inc;
        logic       dec;
        logic [1:0] fsm;
        logic [4:0] cnt;
        logic [4:0] left;
        logic       busy;
        logic       done;
    } vec_t;

    vec_t vt[14];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic check_all(input string tag, input logic [4:0] c, input logic [4:0] l,
                             input logic b, input logic d);
        check({tag, ".count_time"}, 32'(count_time), 32'(c));
        check({tag, ".time_left"},  32'(time_left),  32'(l));
        check({tag, ".busy"},       32'(busy),       32'(b));
        check({tag, ".done"},       32'(done),       32'(d));
    endtask

    // Drive inputs just after an edge, clock once, sample 1 time unit after the next edge.
    task automatic cyc(input logic i, input logic d, input logic [1:0] f);
        inc = i;
        dec = d;
        fsm = f;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int m;
        logic [4:0] exp_left;

        inc = 0; dec = 0; fsm = 2'b00;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #2;
        check_all("reset_async", 5'd10, 5'd0, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            cyc(0, 0, 2'b00);
            check_all("post_reset", 5'd10, 5'd0, 1'b0, 1'b0);
        end

        // 4 increase pulses, 2 decrease pulses, then a simultaneous press.
        vt[0]  = '{1, 0, 2'b00, 5'd11, 5'd0, 0, 0};
        vt[1]  = '{0, 0, 2'b00, 5'd11, 5'd0, 0, 0};
        vt[2]  = '{1, 0, 2'b00, 5'd12, 5'd0, 0, 0};
        vt[3]  = '{0, 0, 2'b00, 5'd12, 5'd0, 0, 0};
        vt[4]  = '{1, 0, 2'b00, 5'd13, 5'd0, 0, 0};
        vt[5]  = '{0, 0, 2'b00, 5'd13, 5'd0, 0, 0};
        vt[6]  = '{1, 0, 2'b00, 5'd14, 5'd0, 0, 0};
        vt[7]  = '{0, 0, 2'b00, 5'd14, 5'd0, 0, 0};
        vt[8]  = '{0, 1, 2'b00, 5'd13, 5'd0, 0, 0};
        vt[9]  = '{0, 0, 2'b00, 5'd13, 5'd0, 0, 0};
        vt[10] = '{0, 1, 2'b00, 5'd12, 5'd0, 0, 0};
        vt[11] = '{0, 0, 2'b00, 5'd12, 5'd0, 0, 0};
        vt[12] = '{1, 1, 2'b00, 5'd12, 5'd0, 0, 0};
        vt[13] = '{0, 0, 2'b00, 5'd12, 5'd0, 0, 0};
        for (int v = 0; v < 14; v++) begin
            cyc(vt[v].inc, vt[v].dec, vt[v].fsm);
            check_all($sformatf("vec%0d", v), vt[v].cnt, vt[v].left, vt[v].busy, vt[v].done);
        end

        // Saturation at T_MAX then T_MIN.
        m = 12;
        for (int k = 0; k < 25; k++) begin
            cyc(1, 0, 2'b00);
            m = (m + 1 > 30) ? 30 : m + 1;
            check($sformatf("sat_up%0d", k), 32'(count_time), 32'(m));
            cyc(0, 0, 2'b00);
        end
        for (int k = 0; k < 40; k++) begin
            cyc(0, 1, 2'b00);
            m = (m - 1 < 2) ? 2 : m - 1;
            check($sformatf("sat_dn%0d", k), 32'(count_time), 32'(m));
            cyc(0, 0, 2'b00);
        end
        cyc(1, 0, 2'b00);
        cyc(0, 0, 2'b00);
        check("set3", 32'(count_time), 32'd3);

        // Exposure of 3 units with PRESCALE 4; buttons pressed mid-run must be ignored.
        for (int k = 0; k < 15; k++) begin
            cyc(k == 2, k == 5, 2'b01);
            exp_left = (k >= 12) ? 5'd0 : 5'(3 - k / 4);
            check_all($sformatf("run3_k%0d", k), 5'd3, exp_left, k < 12, k == 12);
        end
        // Increase held across the return to IDLE must not step.
        cyc(1, 0, 2'b01);
        cyc(1, 0, 2'b00);
        check_all("held_return", 5'd3, 5'd0, 1'b0, 1'b0);
        cyc(1, 0, 2'b00);
        cyc(0, 0, 2'b00);
        check_all("held_release", 5'd3, 5'd0, 1'b0, 1'b0);

        // Setting 5, abort at entry+9.
        cyc(1, 0, 2'b00); cyc(0, 0, 2'b00);
        cyc(1, 0, 2'b00); cyc(0, 0, 2'b00);
        check("set5", 32'(count_time), 32'd5);
        for (int k = 0; k < 9; k++) begin
            cyc(0, 0, 2'b01);
            check_all($sformatf("run5_k%0d", k), 5'd5, 5'(5 - k / 4), 1'b1, 1'b0);
        end
        cyc(0, 0, 2'b10);
        check_all("abort", 5'd5, 5'd3, 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            cyc(0, 0, 2'b11);
            check_all($sformatf("aborted%0d", k), 5'd5, 5'd3, 1'b0, 1'b0);
        end
        cyc(0, 0, 2'b00);
        check_all("back_idle", 5'd5, 5'd3, 1'b0, 1'b0);
        cyc(0, 0, 2'b01);
        check_all("reload", 5'd5, 5'd5, 1'b1, 1'b0);
        cyc(0, 0, 2'b01);
        cyc(0, 0, 2'b01);
        #2 rst_n = 1'b0;
        #1;
        check_all("reset_midrun", 5'd10, 5'd0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        fsm = 2'b00;
        rst_n = 1'b1;
        cyc(0, 0, 2'b00);
        check_all("after_reset", 5'd10, 5'd0, 1'b0, 1'b0);

        // Increase held for 20 clocks.
        for (int k = 0; k < 20; k++) begin
            cyc(1, 0, 2'b00);
`ifdef CTRL_EXP_AUTOREPEAT_EN
            check($sformatf("hold_k%0d", k), 32'(count_time), 32'(11 + k / 8));
`else
            check($sformatf("hold_k%0d", k), 32'(count_time), 32'd11);
`endif
        end
        cyc(0, 0, 2'b00);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
